// File: rtl/mem_req_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_req_responder
// Purpose  : Memory-side responder for the icache/dcache request protocol.
//            Arbitrates instruction fetches and data accesses onto a single
//            RAM port and returns the one-cycle wait-low completion pulse to
//            the requester that was granted.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   ADDR_W   : address width of request and RAM address ports
//   DATA_W   : data word width
// Ports
//   CLK, nRST              : clock (rising edge), async active-low reset
//   iREN, iaddr            : instruction read request / address
//   iwait, iload           : instruction completion (low) / read data
//   dREN, dWEN, daddr,
//   dstore                 : data read / write request, address, write data
//   dwait, dload           : data completion (low) / read data
//   ramREN, ramWEN         : RAM read / write strobes
//   ramaddr, ramstore      : RAM address / write data
//   ramload, ramready      : RAM read data / access-complete indication
// Configuration
//   MEMREQ_RR_ARB_EN       : when defined, round-robin arbitration between
//                            the two requesters on contention; otherwise
//                            data requests always win.
// ============================================================================
module mem_req_responder #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ramready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] IACC = 2'd1;
  localparam logic [1:0] DACC = 2'd2;

  logic [1:0]        state;
  logic [1:0]        next_state;
  logic              d_req;
  logic              grant_d;
  logic              grant;
  logic              i_done;
  logic              d_done;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] store_q;
  logic              wr_q;
  logic [DATA_W-1:0] iload_q;
  logic [DATA_W-1:0] dload_q;

  assign d_req = dREN | dWEN;
  // A grant is taken only from IDLE, which also enforces the bubble cycle
  // between consecutive accesses.
  assign grant = (state == IDLE) && (d_req || iREN);

`ifdef MEMREQ_RR_ARB_EN
  // last_d: 1 = data side won the most recent grant, 0 = instruction side.
  logic last_d;

  // Under contention the side that did not win last time is chosen; a lone
  // requester always wins.
  always_comb begin
    grant_d = d_req & (~iREN | ~last_d);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      last_d <= 1'b0;
    end else if (grant) begin
      last_d <= grant_d;
    end
  end
`else
  always_comb begin
    grant_d = d_req;
  end
`endif

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: an access always runs until ramready, even if the
  // requester has dropped its request meanwhile.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (grant) begin
          next_state = grant_d ? DACC : IACC;
        end
      end
      IACC, DACC: begin
        if (ramready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Request latching and held read data. Address/data/op are captured on the
  // grant edge so later changes by the requester have no effect.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      addr_q  <= '0;
      store_q <= '0;
      wr_q    <= 1'b0;
      iload_q <= '0;
      dload_q <= '0;
    end else begin
      if (grant) begin
        addr_q  <= grant_d ? daddr : iaddr;
        store_q <= dstore;
        wr_q    <= grant_d & dWEN;
      end
      if (i_done) begin
        iload_q <= ramload;
      end
      if (d_done && !wr_q) begin
        dload_q <= ramload;
      end
    end
  end

  // Output logic: strobes depend on state only, so they are zero in IDLE and
  // drop as soon as reset clears the state register.
  always_comb begin
    i_done   = (state == IACC) && ramready;
    d_done   = (state == DACC) && ramready;
    ramREN   = (state == IACC) || ((state == DACC) && !wr_q);
    ramWEN   = (state == DACC) && wr_q;
    ramaddr  = addr_q;
    ramstore = store_q;
    iwait    = ~i_done;
    dwait    = ~d_done;
    iload    = i_done ? ramload : iload_q;
    dload    = (d_done && !wr_q) ? ramload : dload_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_req_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_req_responder
// Purpose  : Self-checking bench for mem_req_responder. A table of accesses
//            is applied in a loop; a scoreboard holds the expected completion
//            of each granted access and is consumed when a wait pulse is
//            seen. Hand-written sequences cover contention and async reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_req_responder;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN, ramready;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;

  mem_req_responder #(.ADDR_W(32), .DATA_W(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          side;   // 0 = instruction, 1 = data
    bit          dren;
    bit          dwen;
    logic [31:0] addr;
    logic [31:0] store;
    int          delay;  // strobe cycles with ramready=0 before completion
    logic [31:0] rdata;
    bit          drop;   // data requester drops request after grant
  } vec_t;

  typedef struct {
    bit          side;
    logic [31:0] data;
  } sb_t;

  sb_t         sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_iload = 32'h0;
  logic [31:0] m_dload = 32'h0;
`ifdef MEMREQ_RR_ARB_EN
  bit          m_last_d = 1'b0;
`endif
  vec_t        tbl[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle();
    chk("idle ramREN", ramREN, 1'b0);
    chk("idle ramWEN", ramWEN, 1'b0);
    chk("idle iwait", iwait, 1'b1);
    chk("idle dwait", dwait, 1'b1);
    chk("idle iload held", iload, m_iload);
    chk("idle dload held", dload, m_dload);
  endtask

  task automatic drive_req(input vec_t v);
    if (v.side) begin
      dREN = v.dren; dWEN = v.dwen; daddr = v.addr; dstore = v.store;
    end else begin
      iREN = 1'b1; iaddr = v.addr;
    end
  endtask

  // Called just after a rising edge with the request(s) already driven and
  // the DUT in IDLE; returns just after the edge that ends the access.
  task automatic serve(input vec_t v);
    bit  wr;
    sb_t e;
    wr = v.side & v.dwen;
    @(negedge CLK);
    check_idle();
    sb.push_back('{v.side, wr ? m_dload : v.rdata});
`ifdef MEMREQ_RR_ARB_EN
    m_last_d = v.side;
`endif
    for (int k = 0; k <= v.delay; k++) begin
      @(posedge CLK); #1;
      if (v.drop && k == 1) begin
        dREN = 1'b0; dWEN = 1'b0; daddr = ~daddr;
        iREN = 1'b1; iaddr = 32'h48;
      end
      ramready = (k == v.delay);
      ramload  = (k == v.delay) ? v.rdata : (32'hBAD0_0000 + k);
      @(negedge CLK);
      chk("ramREN", ramREN, !wr);
      chk("ramWEN", ramWEN, wr);
      chk("ramaddr", ramaddr, v.addr);
      if (wr) chk("ramstore", ramstore, v.store);
      chk("completion cycle", (!iwait || !dwait), (k == v.delay));
      if (!iwait || !dwait) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected wait pulse: iwait=%b dwait=%b", iwait, dwait);
        end else begin
          e = sb.pop_front();
          chk("iwait pulse", iwait, e.side);
          chk("dwait pulse", dwait, !e.side);
          chk("load value", e.side ? dload : iload, e.data);
        end
      end
    end
    if (!wr) begin
      if (v.side) m_dload = v.rdata; else m_iload = v.rdata;
    end
    @(posedge CLK); #1;
    ramready = 1'b0;
    if (v.side) begin dREN = 1'b0; dWEN = 1'b0; end else iREN = 1'b0;
  endtask

  task automatic contention(input logic [31:0] ia, input logic [31:0] da,
                            input logic [31:0] ir, input logic [31:0] dr);
    vec_t vi, vd;
    bit   exp_d;
`ifdef MEMREQ_RR_ARB_EN
    exp_d = ~m_last_d;
`else
    exp_d = 1'b1;
`endif
    vi = '{1'b0, 1'b0, 1'b0, ia, 32'h0, 1, ir, 1'b0};
    vd = '{1'b1, 1'b1, 1'b0, da, 32'h0, 0, dr, 1'b0};
    iREN = 1'b1; iaddr = ia;
    dREN = 1'b1; dWEN = 1'b0; daddr = da;
    if (exp_d) begin serve(vd); serve(vi); end
    else       begin serve(vi); serve(vd); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0; ramready = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0;

    tbl[0] = '{1'b0, 1'b0, 1'b0, 32'h40, 32'h0,        2, 32'hDEADBEEF, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 32'h80, 32'h12345678, 0, 32'h0,        1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h84, 32'h0,        1, 32'hCAFEF00D, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 32'h44, 32'h0,        0, 32'h0BADC0DE, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 32'h10, 32'hA5A5A5A5, 1, 32'h99999999, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 32'h20, 32'h0,        3, 32'h11223344, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 32'h48, 32'h0,        1, 32'h55667788, 1'b0};

    // Reset state, with a request present that must be ignored.
    #7;
    iREN = 1'b1; iaddr = 32'h123;
    chk("reset ramaddr", ramaddr, 32'h0);
    chk("reset ramstore", ramstore, 32'h0);
    chk("reset iload", iload, 32'h0);
    chk("reset dload", dload, 32'h0);
    @(negedge CLK);
    chk("reset ramREN", ramREN, 1'b0);
    chk("reset ramWEN", ramWEN, 1'b0);
    chk("reset iwait", iwait, 1'b1);
    chk("reset dwait", dwait, 1'b1);
    iREN = 1'b0;
    #2 nRST = 1'b1;

    // ramready while idle must not produce a pulse.
    @(posedge CLK); #1;
    ramready = 1'b1; ramload = 32'hFFFFFFFF;
    @(negedge CLK);
    check_idle();
    @(posedge CLK); #1;
    ramready = 1'b0;

    for (int i = 0; i < 7; i++) begin
      drive_req(tbl[i]);
      serve(tbl[i]);
    end

    // Last grant was instruction: both builds serve data first.
    contention(32'h100, 32'h200, 32'hA0A0A0A0, 32'hB0B0B0B0);
    // Last grant is data here: round-robin serves instruction first.
    v = '{1'b1, 1'b1, 1'b0, 32'h204, 32'h0, 0, 32'hC0C0C0C0, 1'b0};
    drive_req(v);
    serve(v);
    contention(32'h104, 32'h208, 32'hD0D0D0D0, 32'hE0E0E0E0);

    // Asynchronous reset in the middle of an instruction access.
    iREN = 1'b1; iaddr = 32'h300;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("pre-reset ramREN", ramREN, 1'b1);
    #2 nRST = 1'b0;
    ramready = 1'b1; ramload = 32'h77777777;
    #1;
    chk("async reset ramREN", ramREN, 1'b0);
    chk("async reset iwait", iwait, 1'b1);
    chk("async reset dwait", dwait, 1'b1);
    chk("async reset iload", iload, 32'h0);
    chk("async reset dload", dload, 32'h0);
    iREN = 1'b0; ramready = 1'b0;
    m_iload = 32'h0; m_dload = 32'h0;
`ifdef MEMREQ_RR_ARB_EN
    m_last_d = 1'b0;
`endif
    @(negedge CLK);
    #2 nRST = 1'b1;
    @(posedge CLK); #1;
    v = '{1'b0, 1'b0, 1'b0, 32'h304, 32'h0, 1, 32'h13579BDF, 1'b0};
    drive_req(v);
    serve(v);

    chk("scoreboard drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
